// File: rtl/tt_scan_pkg.sv
// Shared types and sizes for the tt_scan truth-table scanner.
package tt_scan_pkg;

    localparam int TT_IDX_W    = 4;
    localparam int TT_NUM_VEC  = 16;
    localparam int TT_SETTLE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    function automatic logic tt_is_last(input logic [TT_IDX_W-1:0] idx);
        return idx == TT_IDX_W'(TT_NUM_VEC - 1);
    endfunction

endpackage

// File: rtl/tt_scan_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
module tt_scan_settle_timer
    import tt_scan_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   en,
    input  logic [TT_SETTLE_W-1:0] load_val,
    output logic                   expire
);

    logic [TT_SETTLE_W-1:0] count_r;

    // Count down while enabled, parking at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {TT_SETTLE_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {TT_SETTLE_W{1'b0}})) begin
            count_r <= count_r - TT_SETTLE_W'(1);
        end
    end

    assign expire = (count_r == {TT_SETTLE_W{1'b0}});

endmodule

// File: rtl/tt_scan.sv
// Sequential truth-table scanner: drives 16 vectors, samples b, compares with expected.
// Optional build macro TT_SCAN_STOP_ON_MISMATCH_EN ends the scan at the first mismatch.
module tt_scan
    import tt_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        b,
    output logic        x1,
    output logic        y1,
    output logic        x2,
    output logic        y2,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        match,
    output logic [3:0]  mismatch_idx
);

    // The timer counts SETTLE cycles; SAMPLE supplies the final cycle of each hold.
    localparam logic [TT_SETTLE_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES == 0) ? TT_SETTLE_W'(0) : TT_SETTLE_W'(SETTLE_CYCLES - 1);
    localparam tt_state_t VEC_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    tt_state_t             state_r;
    logic [TT_IDX_W-1:0]   idx_r;
    logic [15:0]           exp_r;
    logic [15:0]           table_r;
    logic                  match_r;
    logic                  mm_seen_r;
    logic [TT_IDX_W-1:0]   mm_idx_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  sample_miss_s;
    logic                  stop_s;
    logic                  end_s;
    logic                  timer_load_s;
    logic                  timer_en_s;
    logic                  timer_expire_s;

    assign sample_miss_s = (b != exp_r[idx_r]);

`ifdef TT_SCAN_STOP_ON_MISMATCH_EN
    assign stop_s = sample_miss_s;
`else
    assign stop_s = 1'b0;
`endif

    assign end_s        = tt_is_last(idx_r) || stop_s;
    assign timer_load_s = ((state_r == IDLE) && start) || ((state_r == SAMPLE) && !end_s);
    assign timer_en_s   = (state_r == SETTLE);

    tt_scan_settle_timer u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load_s),
        .en       (timer_en_s),
        .load_val (SETTLE_LOAD),
        .expire   (timer_expire_s)
    );

    // Scan FSM with its index, captured table and compare results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            idx_r     <= {TT_IDX_W{1'b0}};
            exp_r     <= 16'h0000;
            table_r   <= 16'h0000;
            match_r   <= 1'b0;
            mm_seen_r <= 1'b0;
            mm_idx_r  <= {TT_IDX_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        exp_r     <= expected;
                        idx_r     <= {TT_IDX_W{1'b0}};
                        table_r   <= 16'h0000;
                        match_r   <= 1'b0;
                        mm_seen_r <= 1'b0;
                        mm_idx_r  <= {TT_IDX_W{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= VEC_STATE;
                    end
                end
                SETTLE: begin
                    if (timer_expire_s) begin
                        state_r <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_r[idx_r] <= b;
                    if (sample_miss_s && !mm_seen_r) begin
                        mm_seen_r <= 1'b1;
                        mm_idx_r  <= idx_r;
                    end
                    // match is resolved here so it is already valid in the done cycle.
                    if (end_s) begin
                        match_r <= !mm_seen_r && !sample_miss_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + TT_IDX_W'(1);
                        state_r <= VEC_STATE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign x1           = idx_r[3];
    assign y1           = idx_r[2];
    assign x2           = idx_r[1];
    assign y2           = idx_r[0];
    assign busy         = busy_r;
    assign done         = done_r;
    assign table_out    = table_r;
    assign match        = match_r;
    assign mismatch_idx = mm_idx_r;

endmodule
